// File: rtl/arith_pipe_hs.sv
// arith_pipe_hs: 3-stage F = ((A+B)+(C-D))*D pipeline, valid/ready on both sides, tag sideband.
// Define ARITH_PIPE_STATS_EN to add saturating acc_cnt/stall_cnt statistics ports.
module arith_pipe_hs #(
    parameter int W     = 10,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    input  logic [W-1:0]     D,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     F,
    output logic [TAG_W-1:0] out_tag
`ifdef ARITH_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    function automatic logic [W-1:0] mul_lo(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic             vld_p1, vld_p2, vld_p3;
    logic             en_p1, en_p2, en_p3;
    logic [W-1:0]     x1_p1, x2_p1, d_p1;
    logic [W-1:0]     x3_p2, d_p2;
    logic [TAG_W-1:0] tag_p1, tag_p2;

    // A stage may load whenever it is empty or its contents move on this cycle.
    assign en_p3     = !vld_p3 || out_ready;
    assign en_p2     = !vld_p2 || en_p3;
    assign en_p1     = !vld_p1 || en_p2;
    assign in_ready  = en_p1;
    assign out_valid = vld_p3;

    // Stage 1: A+B and C-D (wraps modulo 2^W)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            x1_p1  <= '0;
            x2_p1  <= '0;
            d_p1   <= '0;
            tag_p1 <= '0;
        end else if (en_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                x1_p1  <= A + B;
                x2_p1  <= C - D;
                d_p1   <= D;
                tag_p1 <= in_tag;
            end
        end
    end

    // Stage 2: combine partial sums
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            x3_p2  <= '0;
            d_p2   <= '0;
            tag_p2 <= '0;
        end else if (en_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                x3_p2  <= x1_p1 + x2_p1;
                d_p2   <= d_p1;
                tag_p2 <= tag_p1;
            end
        end
    end

    // Stage 3: multiply; F/out_tag hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p3  <= 1'b0;
            F       <= '0;
            out_tag <= '0;
        end else if (en_p3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                F       <= mul_lo(x3_p2, d_p2);
                out_tag <= tag_p2;
            end
        end
    end

`ifdef ARITH_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (in_valid && in_ready)
                acc_cnt <= sat_inc(acc_cnt);
            if (out_valid && !out_ready)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_arith_pipe_hs.sv
// Scoreboard bench for arith_pipe_hs: expected results queued on accept, checked by a negedge monitor.
// Covers the stats ports when ARITH_PIPE_STATS_EN is defined (instantiated with CNT_W=2).
module tb_arith_pipe_hs;
    localparam int W     = 10;
    localparam int TAG_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     A = '0, B = '0, C = '0, D = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     F;
    logic [TAG_W-1:0] out_tag;
`ifdef ARITH_PIPE_STATS_EN
    logic [CNT_W-1:0] acc_cnt, stall_cnt;
`endif

    arith_pipe_hs #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C), .D(D), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .F(F), .out_tag(out_tag)
`ifdef ARITH_PIPE_STATS_EN
        , .acc_cnt(acc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     f;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_stall = -1;
    bit post_rst = 0;
    bit hold_pend = 0;
    logic [W-1:0]     hold_f;
    logic [TAG_W-1:0] hold_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the arithmetic straight from the formula, reduced modulo 2^W.
    function automatic logic [W-1:0] model_f(input int a, input int b, input int c, input int d);
        int r;
        r = ((a + b) + (c - d)) * d;
        return r[W-1:0];
    endfunction

`ifdef ARITH_PIPE_STATS_EN
    int  m_acc = 0, m_stall = 0;
    bit  stats_on = 0;
    localparam int CMAX = (1 << CNT_W) - 1;
`endif

    // Monitor: samples on the falling edge, the transfer happens at the next rising edge.
    always @(negedge clk) begin
        item_t it;
        cyc++;
`ifdef ARITH_PIPE_STATS_EN
        if (stats_on) begin
            chk("acc_cnt", acc_cnt, m_acc);
            chk("stall_cnt", stall_cnt, m_stall);
        end
        if (rst) begin
            m_acc = 0; m_stall = 0; stats_on = 1;
        end else begin
            if (in_valid && in_ready && m_acc < CMAX) m_acc++;
            if (out_valid && !out_ready && m_stall < CMAX) m_stall++;
        end
`endif
        if (rst) begin
            sb.delete();
            post_rst  = 1;
            hold_pend = 0;
        end else begin
            if (post_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_F", F, 0);
                chk("rst_out_tag", out_tag, 0);
                post_rst = 0;
            end
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_F", F, hold_f);
                chk("hold_tag", out_tag, hold_tag);
            end
            // Ready whenever some slot is free or the head is leaving.
            chk("in_ready", in_ready, (sb.size() < 3) || out_ready);
            if (!out_ready) last_stall = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    it = sb.pop_front();
                    chk("F", F, it.f);
                    chk("out_tag", out_tag, it.tag);
                    if (last_stall < it.cyc) chk("latency", cyc - it.cyc, 3);
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{model_f(int'(A), int'(B), int'(C), int'(D)), in_tag, cyc});
            hold_pend = out_valid && !out_ready;
            hold_f    = F;
            hold_tag  = out_tag;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] d, input logic [TAG_W-1:0] t);
        bit done;
        done = 0;
        A = a; B = b; C = c; D = d; in_tag = t; in_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = in_ready && !rst;
            step();
        end
        in_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] f, input logic [TAG_W-1:0] t);
        for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_F"}, F, f);
        chk({nm, "_tag"}, out_tag, t);
        step();
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;

        send(10'd3, 10'd4, 10'd10, 10'd2, 4'd5);
        expect_out("basic", 10'd30, 4'd5);

        send(10'd1023, 10'd1, 10'd0, 10'd5, 4'd9);
        expect_out("wrap", 10'd999, 4'd9);
        repeat (3) step();

`ifdef ARITH_PIPE_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), TAG_W'(i));
        repeat (4) step();
        @(negedge clk);
        chk("acc_saturated", acc_cnt, 3);
        step();
        out_ready = 1'b0;
        send(10'd7, 10'd8, 10'd9, 10'd1, 4'd3);
        for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
        step();
        @(negedge clk);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_two", stall_cnt, 2);
        step();
        do_reset();
        @(negedge clk);
        chk("acc_after_rst", acc_cnt, 0);
        chk("stall_after_rst", stall_cnt, 0);
        step();
`endif

        for (int i = 0; i < 8; i++)
            send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), TAG_W'(i));
        repeat (5) step();

        out_ready = 1'b0;
        fork
            for (int i = 0; i < 4; i++)
                send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), TAG_W'(8 + i));
            begin
                repeat (8) step();
                out_ready = 1'b1;
            end
        join
        repeat (6) step();

        send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'd1);
        send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'd2);
        A = W'($urandom); in_tag = 4'd3; in_valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        repeat (6) step();

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 64) == 0;
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) step();
        chk("drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
